// File: rtl/d_latch.sv
// Positive-transparent D latch with asynchronous active-low reset.
// Transparent while g=1, holds while g=0; reset wins over g and d.
`timescale 1ns/1ps

module d_latch #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             g,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // The only storage is this inferred latch; every bit is independent.
  always_latch begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (g) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: timed G-clocked scenarios on a 4-bit
// instance plus a directed vector table applied to 4-bit and 8-bit instances.
`timescale 1ns/1ps

module tb_d_latch;

  logic       g;
  logic       rst_n;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks;
  int errors;

  d_latch #(.WIDTH(4)) dut4 (
    .g     (g),
    .rst_n (rst_n),
    .d     (d4),
    .q     (q4)
  );

  d_latch #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .g     (g),
    .rst_n (rst_n),
    .d     (d8),
    .q     (q8)
  );

  typedef struct {
    logic       rst_n;
    logic       g;
    logic [3:0] d4;
    logic [7:0] d8;
    logic [3:0] exp4;
    logic [7:0] exp8;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wait_until(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  initial begin
    vec_t vecs[17];
    checks = 0;
    errors = 0;
    g      = 1'b0;
    rst_n  = 1'b0;
    d4     = 4'h0;
    d8     = 8'h00;

    fork
      // G: period 100, starts low, rises at 50, 150, 250, ...
      begin
        for (int n = 0; n < 17; n++) begin
          #50 g = 1'b1;
          #50 g = 1'b0;
        end
      end
      begin
        wait_until(10);
        check("reset_q4", 64'(q4), 64'h0);
        check("reset_q8", 64'(q8), 64'hA5);
        wait_until(20);
        rst_n = 1'b1;

        // Sweep: D changes while G=0 appear only at the next G rise.
        for (int i = 0; i < 8; i++) begin
          wait_until(25 + 100 * i);
          d4 = 4'(i);
          #1 check("opaque_hold", 64'(q4), (i == 0) ? 64'h0 : 64'(i - 1));
          if (i == 0) begin
            wait_until(30);
            d8 = 8'hFF;
            #1 check("w8_rstval_ff", 64'(q8), 64'hA5);
            wait_until(40);
            d8 = 8'h00;
            #1 check("w8_rstval_00", 64'(q8), 64'hA5);
            wait_until(45);
            d8 = 8'h3C;
          end
          wait_until(51 + 100 * i);
          check("rise_update", 64'(q4), 64'(i));
          if (i == 0) check("w8_first_rise", 64'(q8), 64'h3C);
          wait_until(149 + 100 * i);
          check("pre_rise_hold", 64'(q4), 64'(i));
        end

        // Transparent: D changes while G=1 pass straight through.
        for (int k = 0; k < 8; k++) begin
          wait_until(875 + 100 * k);
          d4 = 4'(8 + k);
          #1 check("transparent", 64'(q4), 64'(8 + k));
          wait_until(910 + 100 * k);
          d4 = 4'(7 - k);
          #1 check("low_phase_hold", 64'(q4), 64'(8 + k));
          wait_until(940 + 100 * k);
          d4 = 4'(8 + k);
          #1 check("low_phase_hold2", 64'(q4), 64'(8 + k));
        end
      end
    join

    vecs[0]  = '{1'b1, 1'b1, 4'hA, 8'hFF, 4'hA, 8'hFF};
    vecs[1]  = '{1'b0, 1'b1, 4'hA, 8'hFF, 4'h0, 8'hA5};
    vecs[2]  = '{1'b1, 1'b1, 4'hA, 8'hFF, 4'hA, 8'hFF};
    vecs[3]  = '{1'b1, 1'b1, 4'h7, 8'h00, 4'h7, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 4'h7, 8'h00, 4'h7, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 4'h3, 8'h5A, 4'h7, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 4'h3, 8'h5A, 4'h0, 8'hA5};
    vecs[7]  = '{1'b1, 1'b0, 4'hC, 8'h81, 4'h0, 8'hA5};
    vecs[8]  = '{1'b1, 1'b0, 4'hE, 8'h7E, 4'h0, 8'hA5};
    vecs[9]  = '{1'b1, 1'b1, 4'hE, 8'h7E, 4'hE, 8'h7E};
    vecs[10] = '{1'b1, 1'b1, 4'h1, 8'h01, 4'h1, 8'h01};
    vecs[11] = '{1'b1, 1'b1, 4'h8, 8'h80, 4'h8, 8'h80};
    vecs[12] = '{1'b1, 1'b0, 4'h5, 8'hFF, 4'h8, 8'h80};
    vecs[13] = '{1'b0, 1'b1, 4'hF, 8'hFF, 4'h0, 8'hA5};
    vecs[14] = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'h0, 8'hA5};
    vecs[15] = '{1'b1, 1'b1, 4'hF, 8'hFF, 4'hF, 8'hFF};
    vecs[16] = '{1'b1, 1'b1, 4'h0, 8'h00, 4'h0, 8'h00};

    // Gate/reset settle before data moves, so a falling G never races D.
    for (int v = 0; v < 17; v++) begin
      rst_n = vecs[v].rst_n;
      g     = vecs[v].g;
      #1;
      d4    = vecs[v].d4;
      d8    = vecs[v].d8;
      #4;
      check($sformatf("vec%0d_q4", v), 64'(q4), 64'(vecs[v].exp4));
      check($sformatf("vec%0d_q8", v), 64'(q8), 64'(vecs[v].exp8));
    end

    // Reset pulse mid-hold: stays at RST_VAL through the low phase, then follows D.
    g     = 1'b1;
    d4    = 4'h7;
    d8    = 8'h77;
    #5 g  = 1'b0;
    #5 rst_n = 1'b0;
    #1 check("hold_rst_q4", 64'(q4), 64'h0);
    check("hold_rst_q8", 64'(q8), 64'hA5);
    #4 rst_n = 1'b1;
    d4 = 4'h9;
    d8 = 8'h96;
    #10 check("hold_rst_keep_q4", 64'(q4), 64'h0);
    check("hold_rst_keep_q8", 64'(q8), 64'hA5);
    g = 1'b1;
    #1 check("hold_rst_rise_q4", 64'(q4), 64'h9);
    check("hold_rst_rise_q8", 64'(q8), 64'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 WIDTH, default 4, data width in bits (legal range 1..64).
REQ-002 RST_VAL, default all-zeros (WIDTH bits), value Q takes while reset is asserted.
REQ-003 G  input  1  single clock/gate; latch is transparent while G=1 and opaque while G=0.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 D  input  WIDTH  data in.
REQ-006 Q  output  WIDTH  latched data out.

Function
REQ-007 The block SHALL be a level-sensitive, positive-transparent D latch, not an edge-triggered flop.
REQ-008 RST_N=0 SHALL force Q=RST_VAL immediately, with no dependency on G.
REQ-009 Reset SHALL have priority over G; while RST_N=0, D and G SHALL be ignored.
REQ-010 With RST_N=1 and G=1, Q SHALL equal D combinationally, with zero clock latency.
REQ-011 Any D change during G=1 SHALL propagate to Q within the same delta/timestep.
REQ-012 On G falling 1->0 with RST_N=1, Q SHALL capture and hold the D value present at the fall.
REQ-013 With RST_N=1 and G=0, Q SHALL hold its value; all D changes SHALL be ignored.
REQ-014 On G rising 0->1, Q SHALL update to the current D immediately. D applied earlier during G=0 therefore appears at this rising edge.
REQ-015 Simultaneous D change and G fall: Q SHALL take the D value before the change (hold-time-safe capture). Implementers SHALL NOT rely on this case in synthesis.
REQ-016 RST_N deasserted while G=1: Q SHALL follow D immediately on release.
REQ-017 RST_N deasserted while G=0: Q SHALL keep RST_VAL until the next G=1 period.
REQ-018 All WIDTH bits SHALL behave identically and independently, with no arithmetic, truncation or sign handling.
REQ-019 Q SHALL never be X/Z once RST_N has been asserted at least once, provided D is known while G=1.
REQ-020 The design SHALL contain no internal clocks, no derived gates and no combinational feedback other than the inferred latch storage.

Reset
REQ-021 Reset SHALL be asynchronous, active-low, and applied at power-up before the first G high phase.
REQ-022 Reset value of Q SHALL be RST_VAL (default 4'b0000).
REQ-023 Reset assertion mid-transparency SHALL override D at once.
REQ-024 Reset assertion mid-hold SHALL override the held value at once.

Verification
Common setup: WIDTH=4, G period 100 starting low, so G rises at 50, 150, 250, ...

REQ-025 Hold-while-opaque scenario:
- Stimulus: RST_N pulsed low then high before t=25; D=0 at t=25; D=1 at t=125.
- Required: Q=0000 throughout 100-150; Q=0001 exactly at t=150.
REQ-026 Sweep scenario:
- Stimulus: D=I applied at t=25+100*I for I=0..7, so each change occurs while G=0.
- Required: Q updates only at each following G rise; Q=I during 50+100*I .. 150+100*I.
REQ-027 Transparent scenario:
- Stimulus: after a 50-unit shift, D=8..15 applied at t=875, 975, ..., while G=1.
- Required: Q equals the new D at the same timestep.
- Required: Q stays stable through each G low phase.
REQ-028 Reset priority scenario:
- Stimulus: G=1, D=1010; drive RST_N=0.
- Required: Q=0000 immediately.
- Stimulus: release RST_N while G=1.
- Required: Q=1010 immediately.
REQ-029 Reset during hold scenario:
- Stimulus: G=0, Q holds 0111; pulse RST_N low.
- Required: Q=0000, and it stays 0000 until the next G rise.
REQ-030 Parameter scenario:
- Stimulus: WIDTH=8, RST_VAL=8'hA5; reset, then toggle D while G=0.
- Required: Q=A5 until G first rises.
- Required: all 8 bits track D independently, including D=FF and D=00.
